// File: rtl/rover_polar_to_cartesian.sv
// Polar-to-Cartesian converter for the ultrasound locator result: ROM lookup of Q1.8
// sin/cos, an 8-cycle serial shift-add multiply of the distance, then round-half-up.
module rover_polar_to_cartesian #(
  parameter int COEF_W = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               location_done,
  input  logic [11:0]        rover_location,
  output logic               busy,
  output logic               valid,
  output logic signed [9:0]  x,
  output logic signed [9:0]  y,
  output logic               found,
  output logic               angle_error,
  output logic               overrun
);

  // One headroom bit so that +1.0 (256) stays positive in the coefficient registers.
  localparam int CW    = COEF_W + 1;
  localparam int ACC_W = 18;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(128);

  typedef enum logic [1:0] {IDLE, LOOKUP, MUL, ROUND} state_t;

  state_t                   state, state_next;
  logic                     done_d;
  logic                     start;
  logic [11:0]              loc;
  logic signed [CW-1:0]     cos_c, sin_c;
  logic signed [ACC_W-1:0]  acc_x, acc_y;
  logic [2:0]               bit_idx;
  logic                     err;

  function automatic logic signed [CW-1:0] cos_rom(input logic [3:0] code);
    case (code)
      4'd0:    cos_rom = CW'(256);
      4'd1:    cos_rom = CW'(247);
      4'd2:    cos_rom = CW'(222);
      4'd3:    cos_rom = CW'(181);
      4'd4:    cos_rom = CW'(128);
      4'd5:    cos_rom = CW'(66);
      4'd6:    cos_rom = CW'(0);
      4'd7:    cos_rom = CW'(-66);
      4'd8:    cos_rom = CW'(-128);
      4'd9:    cos_rom = CW'(-181);
      4'd10:   cos_rom = CW'(-222);
      4'd11:   cos_rom = CW'(-247);
      default: cos_rom = CW'(0);
    endcase
  endfunction

  function automatic logic signed [CW-1:0] sin_rom(input logic [3:0] code);
    case (code)
      4'd0:    sin_rom = CW'(0);
      4'd1:    sin_rom = CW'(66);
      4'd2:    sin_rom = CW'(128);
      4'd3:    sin_rom = CW'(181);
      4'd4:    sin_rom = CW'(222);
      4'd5:    sin_rom = CW'(247);
      4'd6:    sin_rom = CW'(256);
      4'd7:    sin_rom = CW'(247);
      4'd8:    sin_rom = CW'(222);
      4'd9:    sin_rom = CW'(181);
      4'd10:   sin_rom = CW'(128);
      4'd11:   sin_rom = CW'(66);
      default: sin_rom = CW'(0);
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] partial(input logic signed [CW-1:0] c,
                                                       input logic [2:0] sh);
    partial = ACC_W'(c) <<< sh;
  endfunction

  // Round half up then drop the Q.8 fraction; |result| <= 255 so 10 bits never overflow.
  function automatic logic signed [9:0] round_q8(input logic signed [ACC_W-1:0] acc);
    round_q8 = 10'((acc + HALF) >>> 8);
  endfunction

  assign start = location_done & ~done_d;
  assign busy  = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOOKUP;
      LOOKUP:  state_next = MUL;
      MUL:     if (bit_idx == 3'd7) state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control and visible outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      done_d      <= 1'b1;
      valid       <= 1'b0;
      overrun     <= 1'b0;
      x           <= '0;
      y           <= '0;
      found       <= 1'b0;
      angle_error <= 1'b0;
    end else begin
      state  <= state_next;
      done_d <= location_done;
      valid  <= (state == ROUND);
      if (start && state != IDLE) overrun <= 1'b1;
      if (state == ROUND) begin
        x           <= round_q8(acc_x);
        y           <= round_q8(acc_y);
        found       <= (loc[7:0] != 8'd0) && !err;
        angle_error <= err;
      end
    end
  end

  // Datapath: capture, coefficient load, serial shift-add
  always_ff @(posedge clock) begin
    case (state)
      IDLE: if (start) loc <= rover_location;
      LOOKUP: begin
        cos_c   <= cos_rom(loc[11:8]);
        sin_c   <= sin_rom(loc[11:8]);
        err     <= (loc[11:8] >= 4'd12);
        acc_x   <= '0;
        acc_y   <= '0;
        bit_idx <= 3'd0;
      end
      MUL: begin
        if (loc[bit_idx]) begin
          acc_x <= acc_x + partial(cos_c, bit_idx);
          acc_y <= acc_y + partial(sin_c, bit_idx);
        end
        bit_idx <= bit_idx + 3'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rover_polar_to_cartesian.sv
// Self-checking bench for rover_polar_to_cartesian: directed spec vectors plus random
// conversions against a table-driven arithmetic model, with edge/overrun/reset scenarios.
module tb_rover_polar_to_cartesian;

  logic              clock = 1'b0;
  logic              reset;
  logic              location_done;
  logic [11:0]       rover_location;
  logic              busy, valid, found, angle_error, overrun;
  logic signed [9:0] x, y;

  int errors = 0;
  int checks = 0;

  int cos_t[12] = '{256, 247, 222, 181, 128, 66, 0, -66, -128, -181, -222, -247};
  int sin_t[12] = '{0, 66, 128, 181, 222, 247, 256, 247, 222, 181, 128, 66};

  rover_polar_to_cartesian dut (
    .clock          (clock),
    .reset          (reset),
    .location_done  (location_done),
    .rover_location (rover_location),
    .busy           (busy),
    .valid          (valid),
    .x              (x),
    .y              (y),
    .found          (found),
    .angle_error    (angle_error),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  // Reference: round(d * coef / 256) with ties toward +inf, using floor division.
  function automatic int rnd(input int d, input int c);
    int q;
    q = d * c + 128;
    if (q >= 0) rnd = q / 256;
    else        rnd = -((-q + 255) / 256);
  endfunction

  function automatic void model(input logic [11:0] loc, output int ex, output int ey,
                                output logic ef, output logic ea);
    int code, d;
    code = int'(loc[11:8]);
    d    = int'(loc[7:0]);
    if (code >= 12) begin
      ex = 0; ey = 0; ef = 1'b0; ea = 1'b1;
    end else begin
      ex = rnd(d, cos_t[code]);
      ey = rnd(d, sin_t[code]);
      ef = (d != 0);
      ea = 1'b0;
    end
  endfunction

  // Drives one rising edge and waits (bounded) for valid; cyc = negedges after E0's setup, -1 on timeout.
  task automatic run_conv(input logic [11:0] loc, output int cyc);
    location_done = 1'b0;
    @(negedge clock);
    rover_location = loc;
    location_done  = 1'b1;
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) location_done = 1'b0;
      if (valid) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [11:0] loc, input int cyc);
    int ex, ey;
    logic ef, ea;
    model(loc, ex, ey, ef, ea);
    checks++;
    if (cyc !== 11) begin
      errors++;
      $display("FAIL %s latency: got %0d need 11", name, cyc);
    end
    checks++;
    if (int'(x) !== ex || int'(y) !== ey || found !== ef || angle_error !== ea) begin
      errors++;
      $display("FAIL %s loc=%h: got x=%0d y=%0d f=%b e=%b need x=%0d y=%0d f=%b e=%b",
               name, loc, x, y, found, angle_error, ex, ey, ef, ea);
    end
  endtask

  task automatic test_reset();
    int nv;
    reset = 1'b1; location_done = 1'b1; rover_location = 12'h164;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || x !== 10'sd0 || y !== 10'sd0 ||
        found !== 1'b0 || angle_error !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b valid=%b x=%0d y=%0d f=%b e=%b ov=%b need all 0",
               busy, valid, x, y, found, angle_error, overrun);
    end
    reset = 1'b0;
    nv = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (valid || busy) nv++;
    end
    checks++;
    if (nv !== 0) begin
      errors++;
      $display("FAIL held_through_reset: got %0d active cycles need 0", nv);
    end
    location_done = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_vectors();
    logic [11:0] vec[6] = '{12'h464, 12'h1C8, 12'hBC8, 12'h6FF, 12'h100, 12'hD32};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      run_conv(vec[i], cyc);
      check_result("vector", vec[i], cyc);
    end
    // Literal spot checks straight from the worked examples
    run_conv(12'h464, cyc);
    checks++;
    if (x !== 10'sd50 || y !== 10'sd87 || found !== 1'b1) begin
      errors++;
      $display("FAIL code4_d100: got x=%0d y=%0d f=%b need 50 87 1", x, y, found);
    end
    run_conv(12'hBC8, cyc);
    checks++;
    if (x !== -10'sd193 || y !== 10'sd52) begin
      errors++;
      $display("FAIL code11_d200: got x=%0d y=%0d need -193 52", x, y);
    end
    @(negedge clock);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || x !== -10'sd193) begin
      errors++;
      $display("FAIL pulse_hold: got valid=%b busy=%b x=%0d need 0 0 -193", valid, busy, x);
    end
  endtask

  task automatic test_random();
    logic [11:0] loc;
    int cyc;
    for (int i = 0; i < 24; i++) begin
      loc = 12'($urandom);
      if (i < 4) loc[7:0] = (i < 2) ? 8'hFF : 8'h00;
      run_conv(loc, cyc);
      check_result("random", loc, cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] loc2;
    int cyc;
    loc2 = 12'h37B;
    run_conv(12'h2A0, cyc);
    check_result("b2b_first", 12'h2A0, cyc);
    rover_location = loc2;
    location_done  = 1'b1;
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) location_done = 1'b0;
      if (valid) begin
        cyc = n;
        break;
      end
    end
    check_result("b2b_second", loc2, cyc);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun: got %b need 0", overrun);
    end
  endtask

  task automatic test_overrun();
    int nv, first;
    location_done = 1'b0;
    @(negedge clock);
    rover_location = 12'h496;
    location_done  = 1'b1;
    nv = 0; first = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (n == 1) location_done = 1'b0;
      if (n == 5) begin
        rover_location = 12'h0FF;
        location_done  = 1'b1;
      end
      if (n == 6) location_done = 1'b0;
      if (valid) begin
        nv++;
        if (first < 0) begin
          first = n;
          check_result("overrun_kept", 12'h496, n);
        end
      end
    end
    checks++;
    if (nv !== 1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got valids=%0d ov=%b need 1 1", nv, overrun);
    end
    run_conv(12'h150, first);
    check_result("after_overrun", 12'h150, first);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b need 1", overrun);
    end
  endtask

  task automatic test_held_high();
    int nv;
    location_done = 1'b0;
    @(negedge clock);
    rover_location = 12'h5C8;
    location_done  = 1'b1;
    nv = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (valid) nv++;
    end
    location_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (valid) nv++;
    end
    checks++;
    if (nv !== 1) begin
      errors++;
      $display("FAIL held_high: got %0d valids need 1", nv);
    end
  endtask

  task automatic test_reset_mid();
    int nv, cyc;
    run_conv(12'h0C8, cyc);
    check_result("pre_abort", 12'h0C8, cyc);
    @(negedge clock);
    rover_location = 12'h3C8;
    location_done  = 1'b1;
    nv = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (n == 1) location_done = 1'b0;
      if (n == 6) reset = 1'b1;
      if (n == 7) begin
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || x !== 10'sd0 || y !== 10'sd0 || found !== 1'b0 ||
            angle_error !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL abort_outputs: got busy=%b x=%0d y=%0d f=%b e=%b ov=%b need all 0",
                   busy, x, y, found, angle_error, overrun);
        end
      end
      if (valid) nv++;
    end
    checks++;
    if (nv !== 0) begin
      errors++;
      $display("FAIL abort_no_valid: got %0d valids need 0", nv);
    end
    run_conv(12'h7E1, cyc);
    check_result("after_abort", 12'h7E1, cyc);
  endtask

  initial begin
    reset = 1'b1;
    location_done = 1'b0;
    rover_location = '0;
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_overrun();
    test_held_high();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rover_polar_to_cartesian.md
# rover_polar_to_cartesian

Consumes the ultrasound locator's `{angle, distance}` result and converts it to signed Cartesian coordinates for the display and navigation logic. It captures on the rising edge of the locator's `done` level. It converts with a 15°-step sine/cosine ROM and a shared 8-cycle serial shift-add multiplier, then emits a one-cycle `valid` pulse with `x`, `y` and status flags. It sits directly downstream of the ultrasound location calculator.

## Interface
- `COEF_W`, 9 — signed trig coefficient width, Q1.8 format (256 = 1.0).
- `clock`  in  1  — system clock (27 MHz).
- `reset`  in  1  — synchronous, active-high.
- `location_done`  in  1  — locator `done` level; a rising edge marks a new result.
- `rover_location`  in  12  — `{angle_code[11:8], distance[7:0]}`; angle = angle_code × 15°.
- `busy`  out  1  — high whenever the state is not IDLE.
- `valid`  out  1  — one-cycle pulse when `x`, `y`, `found`, `angle_error` update.
- `x`  out  10  — signed, equal to round(distance·cos θ).
- `y`  out  10  — signed, equal to round(distance·sin θ).
- `found`  out  1  — distance ≠ 0 and angle_code ≤ 11.
- `angle_error`  out  1  — angle_code ≥ 12 on the last conversion.
- `overrun`  out  1  — sticky; set when a rising edge arrives while busy.

## Operation
- Edge detect: `done_d` is registered every cycle. `start = location_done & ~done_d`. `done_d` resets to 1, so a level already high at reset release is not a new result.
- States: IDLE → LOOKUP → MUL → ROUND → IDLE.
- IDLE: on `start`, latch `rover_location` and go to LOOKUP.
- LOOKUP: load `cos_c` and `sin_c` from the ROM indexed by angle_code. Clear both 18-bit signed accumulators. Set `bit_idx` = 0. Go to MUL.
- ROM values for codes 0..11:
  - cos: 256, 247, 222, 181, 128, 66, 0, −66, −128, −181, −222, −247.
  - sin: 0, 66, 128, 181, 222, 247, 256, 247, 222, 181, 128, 66.
  - Codes 12–15 load 0/0 and set the internal error bit.
- MUL: 8 cycles. On each cycle, if `distance[bit_idx]` is set, add `coef <<< bit_idx` (sign-extended to 18 b) to each accumulator. Increment `bit_idx`. After `bit_idx` = 7, go to ROUND.
- ROUND: compute `x = (acc_x + 128) >>> 8` and `y = (acc_y + 128) >>> 8`, truncated to 10 b (range −255..255, no overflow). Update `found` and `angle_error`, assert `valid`, return to IDLE.
- A `start` in any non-IDLE state is dropped and sets `overrun`. Only `reset` clears `overrun`.
- The nothing-found code 12'h100 gives x = 0, y = 0, found = 0, angle_error = 0.

## Timing
- Reset values: `busy` 0, `valid` 0, `x` 0, `y` 0, `found` 0, `angle_error` 0, `overrun` 0, `done_d` 1, state IDLE.
- Cycle numbering: E0 is the edge sampling `start`. LOOKUP happens at E1, MUL at E2–E9, ROUND at E10.
- `valid` is high for exactly the one cycle following E10, i.e. 10 cycles after capture. The outputs hold their values until the next ROUND.
- `busy` is high from after E0 through the end of E10.
- A `start` at E10 (state ROUND) is dropped and flagged as overrun. A `start` on the cycle `valid` is high is accepted, because the state is IDLE.
- `location_done` held high produces a single conversion. It must fall and rise again before another conversion starts.
- `reset` mid-conversion: the next edge returns to IDLE with all outputs at reset values. No `valid` is produced for the aborted input.

## Test plan
- Code 4, distance 100, rising edge at E0 → `valid` in the cycle after E10 with x = 50, y = 87, found = 1.
- Code 1, distance 200 → x = 193, y = 52. Code 11, distance 200 → x = −193, y = 52. Code 6, distance 255 → x = 0, y = 255.
- 12'h100 → x = 0, y = 0, found = 0. Code 13, distance 50 → x = 0, y = 0, angle_error = 1, found = 0.
- Second rising edge at E5 → only one `valid`, overrun = 1 and stays set. Edge timed to the `valid` cycle → accepted, second `valid` 10 cycles later.
- `location_done` held high for 100 cycles → exactly one `valid`. `location_done` high during reset, then held high after reset → no `valid`.
- Reset asserted at E6 → no `valid`, outputs zero. A fresh edge afterwards converts correctly.
